apb_slave_regfile: RTL
======================

// Module: apb_slave_regfile
// PURPOSE
// - APB completer: a 32-bit register bank on one pselx line of the AHB-to-APB bridge.
// - Decodes setup/access phases and latches address, direction and write data on setup.
// - Writes the register bank, returns prdata, flags out-of-range or misaligned accesses.
// - Acts as the responder at the far end of the bridge's APB port, in RTL and in the bench.
// PARAMETERS
// - SEL_IDX      0             pselx bit that selects this slave (0..2)
// - BASE_ADDR    32'h8000_0000 byte address of register 0
// - DEPTH        16            number of 32-bit registers (power of 2, 2..256)
// - WAIT_STATES  0             wait cycles per access (used only with APB_WAIT_EN)
// PORTS
// - hclk       in   1   clock, rising edge
// - hreset     in   1   asynchronous, active-high reset
// - pselx      in   3   one-hot slave selects from the bridge
// - penable    in   1   APB enable (access phase)
// - pwrite     in   1   1 = write, 0 = read
// - paddr      in   32  byte address
// - pwdata     in   32  write data
// - prdata     out  32  read data
// - pready     out  1   transfer complete this access cycle
// - pslverr    out  1   error response, valid when pready=1 in ACCESS
// - proto_err  out  1   sticky protocol-violation flag
// - xfer_cnt   out  16  completed transfers, wraps at 0xFFFF->0
// BEHAVIOUR
// - Reset (async, hreset=1): state=IDLE, all regs=0, prdata=0, pslverr=0, proto_err=0, xfer_cnt=0.
//   - pready=1 while in reset.
//   - A pending write is lost; no partial update.
// - sel = pselx[SEL_IDX]. Other pselx bits are ignored.
// - Offset: off = paddr - BASE_ADDR, 32-bit unsigned.
//   - Valid when off < DEPTH*4 and paddr[1:0]==0.
//   - Register index = off[$clog2(DEPTH)+1:2].
// - FSM has two states, IDLE and ACCESS.
// - IDLE:
//   - sel=1, penable=0 (setup cycle): latch pwrite, pwdata, index and valid; go to ACCESS.
//   - On that same edge, prdata <= valid&&!pwrite ? reg[index] : 0, and pslverr <= !valid.
//   - sel=1, penable=1: stay IDLE, proto_err <= 1.
//   - sel=0: stay IDLE.
// - ACCESS with sel=1, penable=1:
//   - pready = (wait_cnt==0), combinational.
//   - While pready=0: wait_cnt decrements each cycle.
//   - On the edge with pready=1, the transfer completes:
//     - latched write and valid: reg[index] <= latched pwdata;
//     - xfer_cnt++ (error transfers included);
//     - go to IDLE.
// - ACCESS with sel=0 or penable=0: abort to IDLE, no write, no count, proto_err <= 1.
// - Latency:
//   - Read data is valid for the whole ACCESS phase (registered at the setup edge).
//   - A write is visible to a setup cycle that directly follows its completing edge.
//   - Minimum 2 cycles per transfer.
// - Back-to-back transfers: the cycle after a completing ACCESS may be a setup. IDLE decodes it.
// - Error transfers: no register changes; prdata=0; pslverr=1 only in ACCESS.
// - pslverr returns to 0 on entry to IDLE.
// - paddr, pwrite and pwdata changes during ACCESS are ignored; latched values are used.
// - Outside ACCESS, pready=1.
// - proto_err clears only on reset.
// CONFIGURATION
// - APB_WAIT_EN defined:
//   - wait_cnt loads WAIT_STATES at the setup edge.
//   - pready=0 for WAIT_STATES ACCESS cycles, then 1.
// - APB_WAIT_EN undefined:
//   - No wait counter; pready is constant 1.
//   - Every ACCESS completes in one cycle; WAIT_STATES is ignored.
// TESTING
// - Write 0xDEAD_BEEF to 0x8000_0008, then read it -> prdata=0xDEAD_BEEF in ACCESS, pslverr=0, xfer_cnt=2.
// - Back-to-back write 0x1234_5678 @0x8000_0000, then read @0x8000_0000 with no idle -> read returns 0x1234_5678.
// - Write @0x8000_0040 (DEPTH=16) and @0x8000_0002 -> pslverr=1 in ACCESS, all regs unchanged, a read there returns 0.
// - pselx=3'b010 with SEL_IDX=0, write 0xFFFF_FFFF @0x8000_0004 -> reg1 stays 0, xfer_cnt unchanged.
// - penable dropped during ACCESS of a write -> proto_err=1, reg unchanged, FSM in IDLE, next legal write succeeds.
// - APB_WAIT_EN, WAIT_STATES=2:
//   - write -> pready=0,0,1 across ACCESS;
//   - hreset pulsed mid-wait -> pready=1, regs=0, xfer_cnt=0.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer with a DEPTH x 32-bit register bank, error response on bad addresses
// and a sticky protocol-violation flag. Define APB_WAIT_EN to add WAIT_STATES wait cycles per access.
//
// state  | meaning
// IDLE   | waiting for a setup cycle (sel=1, penable=0)
// ACCESS | setup latched; completes when pready=1, aborts if sel or penable drop
module apb_slave_regfile #(
    parameter int unsigned SEL_IDX     = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [2:0]  pselx,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        proto_err,
    output logic [15:0] xfer_cnt
);

    localparam int unsigned IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACCESS = 1'b1;

    logic          state;
    logic [31:0]   regs [DEPTH];
    logic          lat_write;
    logic          lat_valid;
    logic [31:0]   lat_wdata;
    logic [IW-1:0] lat_idx;

    logic          sel;
    logic [31:0]   off;
    logic          addr_ok;
    logic [IW-1:0] idx;
    logic          unused_pselx;

    assign sel          = pselx[SEL_IDX];
    assign unused_pselx = ^pselx;
    assign off          = paddr - BASE_ADDR;
    assign addr_ok      = (off < SPAN) && (paddr[1:0] == 2'b00);
    assign idx          = off[IW+1:2];

`ifdef APB_WAIT_EN
    logic [15:0] wait_cnt;
    assign pready = (state == ST_IDLE) || (wait_cnt == 16'd0);
`else
    assign pready = 1'b1;
`endif

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= ST_IDLE;
            prdata    <= '0;
            pslverr   <= 1'b0;
            proto_err <= 1'b0;
            xfer_cnt  <= '0;
            lat_write <= 1'b0;
            lat_valid <= 1'b0;
            lat_wdata <= '0;
            lat_idx   <= '0;
`ifdef APB_WAIT_EN
            wait_cnt  <= '0;
`endif
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (state == ST_IDLE) begin
            if (sel && !penable) begin
                // Read data is captured here so it is stable for the whole access phase.
                lat_write <= pwrite;
                lat_valid <= addr_ok;
                lat_wdata <= pwdata;
                lat_idx   <= idx;
                prdata    <= (addr_ok && !pwrite) ? regs[idx] : '0;
                pslverr   <= !addr_ok;
                state     <= ST_ACCESS;
`ifdef APB_WAIT_EN
                wait_cnt  <= 16'(WAIT_STATES);
`endif
            end else if (sel && penable) begin
                proto_err <= 1'b1;
            end
        end else begin
            if (!(sel && penable)) begin
                proto_err <= 1'b1;
                pslverr   <= 1'b0;
                state     <= ST_IDLE;
            end else if (pready) begin
                if (lat_write && lat_valid) begin
                    regs[lat_idx] <= lat_wdata;
                end
                xfer_cnt <= xfer_cnt + 16'd1;
                pslverr  <= 1'b0;
                state    <= ST_IDLE;
            end
`ifdef APB_WAIT_EN
            else begin
                wait_cnt <= wait_cnt - 16'd1;
            end
`endif
        end
    end

endmodule
